ps2_keyboard_rx: RTL and testbench

//   Upstream stage of the scancode->ASCII key RAM: receives PS/2 keyboard frames,

---
 rtl/ps2_keyboard_rx_if.sv | 22 ++
 rtl/ps2_keyboard_rx.sv | 227 ++++++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_keyboard_rx_if.sv
// Make-code handshake between the PS/2 receiver and the key RAM.
// The receiver uses the master view; the consumer uses the slave view.
interface ps2_keyboard_rx_if;
    logic       rd_en;
    logic       key_valid;
    logic [7:0] key_code;
    logic [7:0] key_count;

    modport master (
        input  rd_en,
        output key_valid,
        output key_code,
        output key_count
    );

    modport slave (
        output rd_en,
        input  key_valid,
        input  key_code,
        input  key_count
    );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: framing, odd parity, F0/E0 filtering,
// and a small make-code FIFO feeding the scancode->ASCII key RAM.
module ps2_keyboard_rx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    input  logic               clear_err,
    ps2_keyboard_rx_if.master  kb,
    output logic               overflow,
    output logic               parity_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Synchronizers; idle-high reset so reset release never looks like a fall.
    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic dat_s1_q, dat_s2_q;
    logic fall;

    // FSM and frame assembly
    state_t        state_q, state_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          brk_q, brk_d;
    logic          ext_q, ext_d;
    logic          push_req_q, push_req_d;
    logic [7:0]    push_byte_q, push_byte_d;
    logic          frame_err;

    // FIFO and status
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          parity_err_q, parity_err_d;
    logic          full, empty, pop, push_ok, drop;

    // Two-flop synchronizers plus previous-clock flop for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall = clk_prev_q && !clk_s2_q;

    // Frame FSM state register and byte-filter flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            push_req_q  <= 1'b0;
            push_byte_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            push_req_q  <= push_req_d;
            push_byte_q <= push_byte_d;
        end
    end

    // Next-state: bit capture, frame check, break/extend filter, timeout.
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tmo_d       = tmo_q;
        brk_d       = brk_q;
        ext_d       = ext_q;
        push_req_d  = 1'b0;
        push_byte_d = push_byte_q;
        frame_err   = 1'b0;

        if (state_q == IDLE || fall) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (fall && !dat_s2_q) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if ((^{shift_q, par_q}) && dat_s2_q) begin
                        if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else if (brk_q) begin
                            brk_d = 1'b0;
                            ext_d = 1'b0;
                        end else begin
                            ext_d       = 1'b0;
                            push_req_d  = 1'b1;
                            push_byte_d = shift_q;
                        end
                    end else begin
                        frame_err = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A stalled keyboard abandons the partial frame silently.
        if (state_q != IDLE && !fall && tmo_q == TMO_LAST) begin
            state_d = IDLE;
            tmo_d   = '0;
        end
    end

    // FIFO storage, pointers, key counter and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            parity_err_q <= parity_err_d;
        end
    end

    // FIFO control: a pop frees the slot for a same-cycle push when full.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

        pop     = kb.rd_en && !empty;
        push_ok = push_req_q && (!full || pop);
        drop    = push_req_q && full && !pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_byte_q;
            wr_ptr_d = wr_ptr_q + PW'(1);
            count_d  = count_q + 8'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        overflow_d   = (overflow_q && !clear_err) || drop;
        parity_err_d = (parity_err_q && !clear_err) || frame_err;
    end

    assign kb.key_valid = !empty;
    assign kb.key_code  = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign kb.key_count = count_q;
    assign overflow     = overflow_q;
    assign parity_err   = parity_err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: framing, filtering, FIFO,
// timeout and reset behaviour with hand-computed expectations.
module tb_ps2_keyboard_rx;

    localparam int DEPTH = 8;
    localparam int TMO   = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic clear_err = 1'b0;
    logic overflow, parity_err;

    int checks = 0;
    int errors = 0;

    ps2_keyboard_rx_if kb ();

    ps2_keyboard_rx #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .clear_err (clear_err),
        .kb        (kb),
        .overflow  (overflow),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_clk(4);
        ps2_clk = 1'b0;
        wait_clk(4);
        ps2_clk = 1'b1;
    endtask

    // Odd parity: parity bit = ~^data, optionally flipped.
    // With pop_at_push, rd_en covers exactly the push cycle.
    task automatic send_frame(input logic [7:0] b, input logic par_flip,
                              input logic stop, input logic pop_at_push);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ par_flip);
        ps2_data = stop;
        wait_clk(4);
        ps2_clk = 1'b0;
        if (pop_at_push) begin
            wait_clk(3);
            kb.rd_en = 1'b1;
            wait_clk(1);
            kb.rd_en = 1'b0;
        end else begin
            wait_clk(4);
        end
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_clk(10);
    endtask

    task automatic pulse_rd();
        kb.rd_en = 1'b1;
        wait_clk(1);
        kb.rd_en = 1'b0;
        wait_clk(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(2);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({kb.key_valid, kb.key_code, kb.key_count, overflow, parity_err} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b c=%h n=%h o=%b p=%b expected all 0",
                     kb.key_valid, kb.key_code, kb.key_count, overflow, parity_err);
        end
    endtask

    task automatic test_single_make();
        do_reset();
        pulse_rd();
        checks++;
        if (kb.key_valid !== 1'b0 || kb.key_count !== 8'd0) begin
            errors++;
            $display("FAIL rd_empty: got v=%b n=%h expected v=0 n=00", kb.key_valid, kb.key_count);
        end
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        checks++;
        if (kb.key_valid !== 1'b1 || kb.key_code !== 8'h1C || kb.key_count !== 8'd1) begin
            errors++;
            $display("FAIL make_1c: got v=%b c=%h n=%h expected v=1 c=1c n=01",
                     kb.key_valid, kb.key_code, kb.key_count);
        end
        pulse_rd();
        checks++;
        if (kb.key_valid !== 1'b0 || kb.key_code !== 8'h00) begin
            errors++;
            $display("FAIL pop_1c: got v=%b c=%h expected v=0 c=00", kb.key_valid, kb.key_code);
        end
    endtask

    task automatic test_break_ext();
        do_reset();
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        checks++;
        if (kb.key_count !== 8'd1 || kb.key_code !== 8'h1C) begin
            errors++;
            $display("FAIL break_seq: got c=%h n=%h expected c=1c n=01", kb.key_code, kb.key_count);
        end
        send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h75, 1'b0, 1'b1, 1'b0);
        checks++;
        if (kb.key_count !== 8'd2) begin
            errors++;
            $display("FAIL ext_count: got %h expected 02", kb.key_count);
        end
        pulse_rd();
        checks++;
        if (kb.key_valid !== 1'b1 || kb.key_code !== 8'h75) begin
            errors++;
            $display("FAIL ext_75: got v=%b c=%h expected v=1 c=75", kb.key_valid, kb.key_code);
        end
        pulse_rd();
        checks++;
        if (kb.key_valid !== 1'b0) begin
            errors++;
            $display("FAIL ext_drain: got v=%b expected v=0", kb.key_valid);
        end
    endtask

    task automatic test_parity();
        do_reset();
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        checks++;
        if (parity_err !== 1'b1 || kb.key_valid !== 1'b0 || kb.key_count !== 8'd0) begin
            errors++;
            $display("FAIL bad_parity: got p=%b v=%b n=%h expected p=1 v=0 n=00",
                     parity_err, kb.key_valid, kb.key_count);
        end
        clear_err = 1'b1;
        wait_clk(1);
        clear_err = 1'b0;
        wait_clk(1);
        checks++;
        if (parity_err !== 1'b0) begin
            errors++;
            $display("FAIL clear_parity: got %b expected 0", parity_err);
        end
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        checks++;
        if (parity_err !== 1'b1 || kb.key_valid !== 1'b0) begin
            errors++;
            $display("FAIL bad_stop: got p=%b v=%b expected p=1 v=0", parity_err, kb.key_valid);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q [$];
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send_frame(8'h10 + 8'(i), 1'b0, 1'b1, 1'b0);
        end
        checks++;
        if (overflow !== 1'b1 || kb.key_count !== 8'd8 || kb.key_code !== 8'h10) begin
            errors++;
            $display("FAIL overflow: got o=%b n=%h c=%h expected o=1 n=08 c=10",
                     overflow, kb.key_count, kb.key_code);
        end
        clear_err = 1'b1;
        wait_clk(1);
        clear_err = 1'b0;
        wait_clk(1);
        send_frame(8'h20, 1'b0, 1'b1, 1'b1);
        checks++;
        if (overflow !== 1'b0 || kb.key_count !== 8'd9) begin
            errors++;
            $display("FAIL full_push_pop: got o=%b n=%h expected o=0 n=09",
                     overflow, kb.key_count);
        end
        for (int i = 1; i < 8; i++) exp_q.push_back(8'h10 + 8'(i));
        exp_q.push_back(8'h20);
        foreach (exp_q[i]) begin
            checks++;
            if (kb.key_valid !== 1'b1 || kb.key_code !== exp_q[i]) begin
                errors++;
                $display("FAIL fifo_order[%0d]: got v=%b c=%h expected v=1 c=%h",
                         i, kb.key_valid, kb.key_code, exp_q[i]);
            end
            pulse_rd();
        end
        checks++;
        if (kb.key_valid !== 1'b0) begin
            errors++;
            $display("FAIL fifo_drained: got v=%b expected v=0", kb.key_valid);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        wait_clk(TMO + 20);
        send_frame(8'h2A, 1'b0, 1'b1, 1'b0);
        checks++;
        if (kb.key_code !== 8'h2A || kb.key_count !== 8'd1 ||
            parity_err !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL timeout_2a: got c=%h n=%h p=%b o=%b expected c=2a n=01 p=0 o=0",
                     kb.key_code, kb.key_count, parity_err, overflow);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        send_frame(8'h33, 1'b0, 1'b1, 1'b0);
        send_frame(8'h44, 1'b1, 1'b1, 1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b0;
        wait_clk(4);
        ps2_clk = 1'b0;
        wait_clk(1);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({kb.key_valid, kb.key_code, kb.key_count, overflow, parity_err} !== 19'd0) begin
            errors++;
            $display("FAIL async_reset: got v=%b c=%h n=%h o=%b p=%b expected all 0",
                     kb.key_valid, kb.key_code, kb.key_count, overflow, parity_err);
        end
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);
        send_frame(8'h4B, 1'b0, 1'b1, 1'b0);
        checks++;
        if (kb.key_valid !== 1'b1 || kb.key_code !== 8'h4B || kb.key_count !== 8'd1) begin
            errors++;
            $display("FAIL after_reset: got v=%b c=%h n=%h expected v=1 c=4b n=01",
                     kb.key_valid, kb.key_code, kb.key_count);
        end
    endtask

    initial begin
        kb.rd_en = 1'b0;
        test_reset();
        test_single_make();
        test_break_ext();
        test_parity();
        test_overflow();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
